// File: rtl/register_file.sv
// 32-entry ARMv8 integer register file: two combinational read ports with write-first bypass, one write port, X31 = XZR.
// Build option REGFILE_INIT_INDEX_EN: reset loads Xi with i instead of 0.
module register_file #(
    parameter int WORD   = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WORD-1:0]   write_data,
    output logic [WORD-1:0]   read_data1,
    output logic [WORD-1:0]   read_data2
);

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NREGS - 1);

    // X0..X30 only; XZR has no storage.
    logic [WORD-1:0] regs_q [NREGS-1];

    logic wr_en;
    logic byp_en;

    assign byp_en = rst_n && regWrite;
    assign wr_en  = byp_en && (write_reg != XZR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS - 1; i++) begin
`ifdef REGFILE_INIT_INDEX_EN
                regs_q[i] <= WORD'(i);
`else
                regs_q[i] <= '0;
`endif
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // XZR check comes first so a write aimed at X31 is never forwarded.
    always_comb begin
        read_data1 = '0;
        if (read_reg1 != XZR) begin
            if (byp_en && (write_reg == read_reg1)) read_data1 = write_data;
            else                                    read_data1 = regs_q[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (read_reg2 != XZR) begin
            if (byp_en && (write_reg == read_reg2)) read_data2 = write_data;
            else                                    read_data2 = regs_q[read_reg2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed + randomized scoreboard bench for register_file.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regWrite;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [63:0] write_data;
    logic [63:0] read_data1, read_data2;

    register_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regWrite   (regWrite),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [63:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t    sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] mdl [31];

    function automatic logic [63:0] init_val(int i);
`ifdef REGFILE_INIT_INDEX_EN
        return 64'(i);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] model_read(logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (rst_n && regWrite && write_reg == idx) return write_data;
        return mdl[idx];
    endfunction

    task automatic expect_rd(int port, logic [63:0] exp, string tag);
        sb_item_t it;
        it.port = port;
        it.exp  = exp;
        it.tag  = tag;
        sb.push_back(it);
    endtask

    task automatic check_all();
        sb_item_t    it;
        logic [63:0] obs;
        #1;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = (it.port == 1) ? read_data1 : read_data2;
            n_checks++;
            assert (obs === it.exp) n_pass++;
            else $error("FAIL %s port%0d observed=%h expected=%h", it.tag, it.port, obs, it.exp);
        end
    endtask

    // Advance one edge and mirror what that edge should have done to storage.
    task automatic tick();
        logic        r_n  = rst_n;
        logic        we   = regWrite;
        logic [4:0]  wr   = write_reg;
        logic [63:0] wd   = write_data;
        @(posedge clk);
        #1;
        if (!r_n) begin
            for (int i = 0; i < 31; i++) mdl[i] = init_val(i);
        end else if (we && wr != 5'd31) begin
            mdl[wr] = wd;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wide_idx;
        rst_n = 1'b0; regWrite = 1'b0; read_reg1 = '0; read_reg2 = '0;
        write_reg = '0; write_data = '0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Reset contents
        read_reg1 = 5'd10; read_reg2 = 5'd15;
        expect_rd(1, init_val(10), "reset_x10");
        expect_rd(2, init_val(15), "reset_x15");
        check_all();

        // Bypass and persistence
        regWrite = 1'b1; write_reg = 5'd9; write_data = 64'd256; read_reg1 = 5'd9;
        expect_rd(1, 64'd256, "bypass_x9");
        check_all();
        tick();
        regWrite = 1'b0;
        expect_rd(1, 64'd256, "stored_x9");
        check_all();

        // XZR writes dropped, reads zero
        regWrite = 1'b1; write_reg = 5'd31; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read_reg1 = 5'd31; read_reg2 = 5'd31;
        expect_rd(1, 64'd0, "xzr_pre_p1");
        expect_rd(2, 64'd0, "xzr_pre_p2");
        check_all();
        tick();
        regWrite = 1'b0;
        expect_rd(1, 64'd0, "xzr_post_p1");
        expect_rd(2, 64'd0, "xzr_post_p2");
        check_all();

        // Index truncation: 32 -> X0
        regWrite = 1'b1; write_reg = 5'd0; write_data = 64'h1234;
        tick();
        regWrite = 1'b0;
        wide_idx = 32;
        read_reg2 = wide_idx[4:0];
        read_reg1 = 5'd2;
        expect_rd(2, 64'h1234, "trunc_x0");
        expect_rd(1, init_val(2), "unwritten_x2");
        check_all();

        // Reset beats simultaneous write, no bypass while in reset
        rst_n = 1'b0; regWrite = 1'b1; write_reg = 5'd5; write_data = 64'd77;
        read_reg1 = 5'd5; read_reg2 = 5'd9;
        expect_rd(1, init_val(5), "rst_no_bypass_x5");
        expect_rd(2, 64'd256, "rst_stored_x9");
        check_all();
        tick();
        rst_n = 1'b1; regWrite = 1'b0;
        expect_rd(1, init_val(5), "rst_drop_x5");
        expect_rd(2, init_val(9), "rst_clear_x9");
        check_all();

        // Back-to-back writes to X3
        regWrite = 1'b1; write_reg = 5'd3; write_data = 64'd11;
        read_reg1 = 5'd3; read_reg2 = 5'd3;
        expect_rd(1, 64'd11, "b2b_c1_p1");
        expect_rd(2, 64'd11, "b2b_c1_p2");
        check_all();
        tick();
        write_data = 64'd22;
        expect_rd(1, 64'd22, "b2b_c2_p1");
        expect_rd(2, 64'd22, "b2b_c2_p2");
        check_all();
        tick();
        regWrite = 1'b0;
        expect_rd(1, 64'd22, "b2b_after_p1");
        expect_rd(2, 64'd22, "b2b_after_p2");
        check_all();

        // Randomized traffic against the storage model
        for (int n = 0; n < 200; n++) begin
            regWrite   = ($urandom_range(0, 3) != 0);
            write_reg  = 5'($urandom_range(0, 31));
            write_data = {$urandom(), $urandom()};
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = 5'($urandom_range(0, 31));
            expect_rd(1, model_read(read_reg1), "rand_p1");
            expect_rd(2, model_read(read_reg2), "rand_p2");
            check_all();
            tick();
        end

        regWrite = 1'b0;
        for (int i = 0; i < 31; i += 2) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(i + 1);
            expect_rd(1, mdl[i], "sweep_p1");
            expect_rd(2, (i + 1 == 31) ? 64'd0 : mdl[i + 1], "sweep_p2");
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- ARMv8 integer register file for the decode stage: 32 architectural registers X0–X31, each `WORD` (64) bits wide.
- Two asynchronous read ports serve Rn and Rm. One synchronous write port serves Rd, written back from the WB stage.
- Register 31 is the zero register (XZR).
- Write-to-read bypass inside the block replaces the split read/write clocking used elsewhere, so one clock suffices.

Parameters:
- WORD, 64, data width of each register and of all data ports.
- ADDR_W, 5, register index width.
- NREGS, 32, number of architectural registers; index NREGS-1 is XZR.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- regWrite  input  1  write enable for the write port.
- read_reg1  input  ADDR_W  read port 1 index (Rn).
- read_reg2  input  ADDR_W  read port 2 index (Rm).
- write_reg  input  ADDR_W  write index (Rd).
- write_data  input  WORD  data to write.
- read_data1  output  WORD  contents selected by read_reg1.
- read_data2  output  WORD  contents selected by read_reg2.

Behaviour:
- Storage: NREGS-1 flops of WORD bits for X0..X30. X31 has no storage.
- Reset: rst_n sampled low at a rising clk edge clears X0..X30 to 0. Reset has priority over a simultaneous write; the write is discarded. Reset deasserts synchronously; the first write is accepted at the first edge with rst_n high.
- Write: at rising clk edge with rst_n=1, regWrite=1 and write_reg≠31, register[write_reg] <= write_data.
  - regWrite=0: no change.
  - write_reg=31: write silently dropped.
- Read is combinational, zero latency:
  - read_dataN = 0 when read_regN=31.
  - Else read_dataN = write_data when regWrite=1, rst_n=1 and write_reg==read_regN (write-first bypass).
  - Else read_dataN = register[read_regN].
- Bypass is qualified by rst_n. While rst_n=0, reads return stored contents, without forwarding.
- Both read ports are independent. Both may address the same register, including the one being written; both then see the bypassed value.
- Index width is exactly ADDR_W. A driver value of 32 truncates to 0 and reads X0; no out-of-range case exists.
- Outputs carry no X after reset. Before the first reset, contents are undefined.
- No other latency. A value written at edge N is visible from storage after edge N, and combinationally during the write cycle via bypass.

Optional Feature:
- Macro REGFILE_INIT_INDEX_EN.
  - Defined: reset loads each Xi (i=0..30) with the value i, zero-extended to WORD, to ease bring-up and debug. X31 still reads 0.
  - Undefined: reset loads all registers with 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with regWrite=0, then read_reg1=10, read_reg2=15 → read_data1=0 and read_data2=0. With REGFILE_INIT_INDEX_EN: 10 and 15.
- regWrite=1, write_reg=9, write_data=256, read_reg1=9 in the same cycle → read_data1=256 via bypass. After the edge, with regWrite=0, read_data1 still 256.
- regWrite=1, write_reg=31, write_data=0xFFFF_FFFF_FFFF_FFFF; read_reg1=31, read_reg2=31 → both read 0 before and after the edge.
- Driver sets read_reg2=32 (truncated to 0) after X0 was written with 0x1234 → read_data2=0x1234. read_reg1=2, never written → 0 (or 2 with the macro).
- rst_n=0 together with regWrite=1, write_reg=5, write_data=77 at an edge → X5 reads 0 after the edge. No bypass of 77 while rst_n=0.
- Back-to-back writes: X3=11 at edge 1, X3=22 at edge 2, both read ports on 3 → 11 during cycle 1 (bypass), 22 during cycle 2 (bypass), 22 afterwards.
